// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: load/store size codes, LSU state encoding, access helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package riscv_pkg;

    // funct3 size codes, shared with the core decoder
    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_t;

    // Illegal size codes and misaligned halfword/word accesses never reach memory
    function automatic logic lsu_access_err(input logic [2:0] size, input logic [1:0] off);
        logic err;
        case (size)
            LDST_B, LDST_BU: err = 1'b0;
            LDST_H, LDST_HU: err = off[0];
            LDST_W:          err = (off != 2'd0);
            default:         err = 1'b1;
        endcase
        return err;
    endfunction

    // Byte lanes touched by an access; loads use the same encoding as stores
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            LDST_B, LDST_BU: be = 4'b0001 << off;
            LDST_H, LDST_HU: be = 4'b0011 << off;
            LDST_W:          be = 4'b1111;
            default:         be = 4'b0000;
        endcase
        return be;
    endfunction

    // Store data copied to every lane so the byte enables alone pick the target bytes
    function automatic logic [31:0] lsu_store_rep(input logic [1:0] size_lo, input logic [31:0] wd);
        logic [31:0] rep;
        case (size_lo)
            2'd0:    rep = {4{wd[7:0]}};
            2'd1:    rep = {2{wd[15:0]}};
            default: rep = wd;
        endcase
        return rep;
    endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Word-wide data-memory bus between the LSU (master) and memory (slave).
// Latency: n/a (signal bundle only).
// Backpressure: memory holds ready low to stretch an access; master keeps request fields stable.
interface riscv_lsu_if;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        ready;

    modport master (output req, we, be, addr, wd, input rd, ready);
    modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_lsu_load_ext.sv
// Load lane select plus sign/zero extension of a memory read word.
// Latency: combinational.
// Backpressure: none.
module lsu_load_ext
    import riscv_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend according to the size code
    always_comb begin
        shifted = word >> {off, 3'b000};
        result  = 32'd0;
        case (size)
            LDST_B:  result = {{24{shifted[7]}}, shifted[7:0]};
            LDST_BU: result = {24'd0, shifted[7:0]};
            LDST_H:  result = {{16{shifted[15]}}, shifted[15:0]};
            LDST_HU: result = {16'd0, shifted[15:0]};
            LDST_W:  result = shifted;
            default: result = 32'd0;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: latches a core access, drives the data-memory bus, returns extended load data.
// Latency: 3 cycles with zero memory wait states (IDLE->REQ->DONE), 2 cycles for an error access.
// Backpressure: each cycle with mem ready low extends REQ and the core stall by one cycle.
module riscv_lsu
    import riscv_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [2:0]         core_size_i,
    input  logic [31:0]        core_addr_i,
    input  logic [31:0]        core_wd_i,
    output logic [31:0]        core_rd_o,
    output logic               core_stall_o,
    output logic               core_err_o,
    riscv_lsu_if.master        mem
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wd_q;
    logic        err_q;
    logic [31:0] rd_q;
    logic [31:0] ld_result;

    lsu_load_ext u_load_ext (
        .size   (size_q),
        .off    (addr_q[1:0]),
        .word   (mem.rd),
        .result (ld_result)
    );

    // Access FSM; bus outputs are registered so only REQ shows a live request
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= LSU_IDLE;
            addr_q    <= 32'd0;
            size_q    <= 3'd0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            mem_be_q  <= 4'd0;
            mem_wd_q  <= 32'd0;
            err_q     <= 1'b0;
            rd_q      <= 32'd0;
        end else begin
            case (state)
                LSU_IDLE: begin
                    if (core_req_i) begin
                        addr_q   <= core_addr_i;
                        size_q   <= core_size_i;
                        mem_wd_q <= lsu_store_rep(core_size_i[1:0], core_wd_i);
                        if (lsu_access_err(core_size_i, core_addr_i[1:0])) begin
                            err_q <= 1'b1;
                            rd_q  <= 32'd0;
                            state <= LSU_DONE;
                        end else begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= core_we_i;
                            mem_be_q  <= lsu_byte_en(core_size_i, core_addr_i[1:0]);
                            state     <= LSU_REQ;
                        end
                    end
                end
                LSU_REQ: begin
                    // Dropping core_req_i here does not abort: the access runs to completion
                    if (mem.ready) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        mem_be_q  <= 4'd0;
                        rd_q      <= ld_result;
                        state     <= LSU_DONE;
                    end
                end
                LSU_DONE: begin
                    err_q <= 1'b0;
                    state <= LSU_IDLE;
                end
                default: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    mem_be_q  <= 4'd0;
                    err_q     <= 1'b0;
                    state     <= LSU_IDLE;
                end
            endcase
        end
    end

    // Core sees a stall for every requesting cycle except the completion cycle
    always_comb begin
        core_stall_o = core_req_i & (state != LSU_DONE);
    end

    assign core_rd_o  = rd_q;
    assign core_err_o = err_q;

    assign mem.req  = mem_req_q;
    assign mem.we   = mem_we_q;
    assign mem.be   = mem_be_q;
    assign mem.addr = {addr_q[31:2], 2'b00};
    assign mem.wd   = mem_wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

    logic        clk_i;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        core_err_o;

    riscv_lsu_if mem_bus ();

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .core_err_o   (core_err_o),
        .mem          (mem_bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdword;
        int          waits;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_stalls;
    } vec_t;

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: expectations from the access rules using plain arithmetic
    function automatic vec_t model(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                                   input logic [31:0] wd, input logic [31:0] rdword, input int waits);
        vec_t v;
        int nbytes;
        int off;
        logic legal;
        logic sgn;
        longint val;
        logic [31:0] res;
        v.we = we; v.sz = sz; v.addr = addr; v.wd = wd; v.rdword = rdword; v.waits = waits;
        legal = 1'b1; sgn = 1'b0; nbytes = 4;
        case (sz)
            3'd0: begin nbytes = 1; sgn = 1'b1; end
            3'd1: begin nbytes = 2; sgn = 1'b1; end
            3'd2: nbytes = 4;
            3'd4: nbytes = 1;
            3'd5: nbytes = 2;
            default: legal = 1'b0;
        endcase
        off = int'(addr % 4);
        v.exp_err = !legal || ((off % nbytes) != 0);
        v.exp_be = 4'd0;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes) v.exp_be[i] = 1'b1;
        v.exp_wd = 32'd0;
        for (int k = 0; k < 4; k++)
            v.exp_wd = v.exp_wd | (((wd >> (8 * (k % nbytes))) & 32'hFF) << (8 * k));
        val = (longint'(rdword) >> (8 * off)) & ((longint'(1) << (8 * nbytes)) - 1);
        if (sgn && val >= (longint'(1) << (8 * nbytes - 1)))
            val = val - (longint'(1) << (8 * nbytes));
        res = val[31:0];
        v.exp_rd = v.exp_err ? 32'd0 : res;
        v.exp_stalls = v.exp_err ? 1 : 2 + waits;
        return v;
    endfunction

    // One core access, entered and left on a falling edge with the LSU idle
    task automatic run_access(input vec_t v, input string tag);
        int stalls = 0;
        int reqs = 0;
        int wcnt = 0;
        int cyc = 0;
        logic done = 1'b0;
        core_req_i  = 1'b1;
        core_we_i   = v.we;
        core_size_i = v.sz;
        core_addr_i = v.addr;
        core_wd_i   = v.wd;
        mem_bus.ready = 1'b0;
        while (!done) begin
            #1;
            if (!core_stall_o) begin
                done = 1'b1;
                chk({tag, " err"}, {31'd0, core_err_o}, {31'd0, v.exp_err});
                if (!v.we || v.exp_err) chk({tag, " rd"}, core_rd_o, v.exp_rd);
                chk({tag, " stalls"}, stalls, v.exp_stalls);
                chk({tag, " reqs"}, reqs, v.exp_err ? 0 : 1 + v.waits);
                chk({tag, " done_req"}, {31'd0, mem_bus.req}, 32'd0);
                chk({tag, " done_be"}, {28'd0, mem_bus.be}, 32'd0);
                core_req_i    = 1'b0;
                mem_bus.ready = 1'b0;
            end else begin
                stalls++;
                if (mem_bus.req) begin
                    reqs++;
                    chk({tag, " addr"}, mem_bus.addr, {v.addr[31:2], 2'b00});
                    chk({tag, " be"}, {28'd0, mem_bus.be}, {28'd0, v.exp_be});
                    chk({tag, " we"}, {31'd0, mem_bus.we}, {31'd0, v.we});
                    if (v.we) chk({tag, " wd"}, mem_bus.wd, v.exp_wd);
                    mem_bus.ready = (wcnt == v.waits);
                    mem_bus.rd    = (wcnt == v.waits) ? v.rdword : $urandom;
                    wcnt++;
                end else begin
                    mem_bus.ready = 1'b0;
                    mem_bus.rd    = $urandom;
                end
                cyc++;
                if (cyc > 40) begin
                    nvec++; nmis++;
                    $display("FAIL %s timeout stalls=%0d required=%0d", tag, stalls, v.exp_stalls);
                    core_req_i = 1'b0;
                    done = 1'b1;
                end
                @(negedge clk_i);
            end
        end
        @(negedge clk_i);
        #1;
        chk({tag, " idle_err"}, {31'd0, core_err_o}, 32'd0);
        @(negedge clk_i);
    endtask

    vec_t tbl[$];

    initial begin
        rst_ni = 1'b0;
        core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = 3'd0;
        core_addr_i = 32'd0; core_wd_i = 32'd0;
        mem_bus.rd = 32'd0; mem_bus.ready = 1'b0;

        //             we  sz    addr          wd            rdword        w  be       exp_wd        exp_rd        err stalls
        tbl.push_back('{1'b0, 3'd2, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd0, 32'h103, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd4, 32'h103, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'h00000080, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd5, 32'h102, 32'h0,        32'h80112233, 0, 4'b1100, 32'h0,        32'h00008011, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd1, 32'h102, 32'h0,        32'h80112233, 0, 4'b1100, 32'h0,        32'hFFFF8011, 1'b0, 2});
        tbl.push_back('{1'b1, 3'd0, 32'h201, 32'h000000A5, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b1, 3'd1, 32'h202, 32'h00001234, 32'h0,        0, 4'b1100, 32'h12341234, 32'h0,        1'b0, 2});
        tbl.push_back('{1'b0, 3'd2, 32'h300, 32'h0,        32'h12345678, 3, 4'b1111, 32'h0,        32'h12345678, 1'b0, 5});
        tbl.push_back('{1'b0, 3'd2, 32'h102, 32'h0,        32'h55555555, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 3'd0, 32'h100, 32'h0,        32'h0000007F, 0, 4'b0001, 32'h0,        32'h0000007F, 1'b0, 2});
        tbl.push_back('{1'b0, 3'd3, 32'h100, 32'h0,        32'h55555555, 0, 4'b0000, 32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 32'h0,        1, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 3});
        tbl.push_back('{1'b0, 3'd5, 32'h101, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1});
        tbl.push_back('{1'b0, 3'd6, 32'h108, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        1'b1, 1});

        // Reset state
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst mem_req", {31'd0, mem_bus.req}, 32'd0);
        chk("rst mem_we", {31'd0, mem_bus.we}, 32'd0);
        chk("rst mem_be", {28'd0, mem_bus.be}, 32'd0);
        chk("rst core_err", {31'd0, core_err_o}, 32'd0);
        chk("rst core_rd", core_rd_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        foreach (tbl[i]) run_access(tbl[i], $sformatf("tbl%0d", i));

        // Reset asserted while waiting in REQ
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = 3'd2;
        core_addr_i = 32'h400; mem_bus.ready = 1'b0;
        @(negedge clk_i);
        #1;
        chk("mrst req_before", {31'd0, mem_bus.req}, 32'd1);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mrst req_async", {31'd0, mem_bus.req}, 32'd0);
        chk("mrst be_async", {28'd0, mem_bus.be}, 32'd0);
        core_req_i = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        run_access(model(1'b0, 3'd2, 32'h404, 32'h0, 32'hA1B2C3D4, 1), "post_rst");

        // Randomized accesses against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run_access(model(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
                             $urandom, $urandom, int'($urandom_range(0, 3))),
                       $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
